// File: rtl/wb_regfile_pkg.sv
// Shared types and sizing for the writeback register file and the pipeline registers around it.
package wb_regfile_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback value select: load data or ALU result.
module wb_mux #(
    parameter int XLEN = wb_regfile_pkg::XLEN
) (
    input  logic [XLEN-1:0] memData_i,
    input  logic [XLEN-1:0] aluResult_i,
    input  logic            memToReg_i,
    output logic [XLEN-1:0] wbData_o
);

    assign wbData_o = memToReg_i ? memData_i : aluResult_i;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with writeback commit tracking.
// Define REGFILE_BYPASS_EN to forward the writeback value to same-cycle reads.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] WB_MemData,
    input  logic [XLEN-1:0] WB_ALUResult,
    input  reg_idx_t        WB_rd,
    input  logic            WB_MemToReg,
    input  logic            WB_RegWrite,
    input  reg_idx_t        ID_rs1,
    input  reg_idx_t        ID_rs2,
    output logic [XLEN-1:0] ID_rs1Data,
    output logic [XLEN-1:0] ID_rs2Data,
    output logic            commit_valid,
    output reg_idx_t        commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic [63:0]     retired_count
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] wbData;
    logic            writeHit;

    logic            commitValid_q, commitValid_d;
    reg_idx_t        commitRd_q,    commitRd_d;
    logic [XLEN-1:0] commitData_q,  commitData_d;
    logic [63:0]     retiredCount_q, retiredCount_d;

    wb_mux #(.XLEN(XLEN)) u_wbMux (
        .memData_i   (WB_MemData),
        .aluResult_i (WB_ALUResult),
        .memToReg_i  (WB_MemToReg),
        .wbData_o    (wbData)
    );

    // x0 is hardwired: it never counts as a retired write.
    assign writeHit = WB_RegWrite && (WB_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeHit) begin
            regs_q[WB_rd[AW-1:0]] <= wbData;
        end
    end

    always_comb begin
        ID_rs1Data = '0;
        ID_rs2Data = '0;
        if (ID_rs1 != '0) begin
            ID_rs1Data = regs_q[ID_rs1[AW-1:0]];
        end
        if (ID_rs2 != '0) begin
            ID_rs2Data = regs_q[ID_rs2[AW-1:0]];
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst && writeHit && (ID_rs1 == WB_rd)) begin
            ID_rs1Data = wbData;
        end
        if (!rst && writeHit && (ID_rs2 == WB_rd)) begin
            ID_rs2Data = wbData;
        end
`endif
    end

    always_comb begin
        commitValid_d  = writeHit;
        commitRd_d     = commitRd_q;
        commitData_d   = commitData_q;
        retiredCount_d = retiredCount_q;
        if (writeHit) begin
            commitRd_d     = WB_rd;
            commitData_d   = wbData;
            retiredCount_d = retiredCount_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commitValid_q  <= 1'b0;
            commitRd_q     <= '0;
            commitData_q   <= '0;
            retiredCount_q <= '0;
        end else begin
            commitValid_q  <= commitValid_d;
            commitRd_q     <= commitRd_d;
            commitData_q   <= commitData_d;
            retiredCount_q <= retiredCount_d;
        end
    end

    assign commit_valid  = commitValid_q;
    assign commit_rd     = commitRd_q;
    assign commit_data   = commitData_q;
    assign retired_count = retiredCount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] WB_MemData, WB_ALUResult;
    logic [4:0]      WB_rd;
    logic            WB_MemToReg, WB_RegWrite;
    logic [4:0]      ID_rs1, ID_rs2;
    logic [XLEN-1:0] ID_rs1Data, ID_rs2Data;
    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_data;
    logic [63:0]     retired_count;

    logic [XLEN-1:0] mRegs [32];
    logic            mValid;
    logic [4:0]      mRd;
    logic [XLEN-1:0] mData;
    logic [63:0]     mCount;

    int checks;
    int failures;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .WB_MemData    (WB_MemData),
        .WB_ALUResult  (WB_ALUResult),
        .WB_rd         (WB_rd),
        .WB_MemToReg   (WB_MemToReg),
        .WB_RegWrite   (WB_RegWrite),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_rs1Data    (ID_rs1Data),
        .ID_rs2Data    (ID_rs2Data),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_data   (commit_data),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] expectRead(input logic [4:0] rs, input logic r,
                                                   input logic we, input logic [4:0] rd,
                                                   input logic [XLEN-1:0] wb);
        logic [XLEN-1:0] v;
        v = (rs == 5'd0) ? '0 : mRegs[rs];
`ifdef REGFILE_BYPASS_EN
        if (!r && we && rd != 5'd0 && rs == rd) v = wb;
`endif
        return v;
    endfunction

    // One clock of activity: reads checked before the edge, commit outputs after it.
    task automatic cycle(input string tag, input logic r, input logic [XLEN-1:0] mem,
                         input logic [XLEN-1:0] alu, input logic [4:0] rd, input logic m2r,
                         input logic we, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [XLEN-1:0] wb, e1, e2;
        rst = r; WB_MemData = mem; WB_ALUResult = alu; WB_rd = rd;
        WB_MemToReg = m2r; WB_RegWrite = we; ID_rs1 = rs1; ID_rs2 = rs2;
        wb = m2r ? mem : alu;
        #1;
        e1 = expectRead(rs1, r, we, rd, wb);
        e2 = expectRead(rs2, r, we, rd, wb);
        checks++;
        if (ID_rs1Data !== e1) begin
            failures++;
            $display("[TB] FAIL %s rs1Data(x%0d) got %h exp %h", tag, rs1, ID_rs1Data, e1);
        end
        checks++;
        if (ID_rs2Data !== e2) begin
            failures++;
            $display("[TB] FAIL %s rs2Data(x%0d) got %h exp %h", tag, rs2, ID_rs2Data, e2);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mRegs[i] = '0;
            mValid = 1'b0; mRd = '0; mData = '0; mCount = '0;
        end else if (we && rd != 5'd0) begin
            mRegs[rd] = wb;
            mValid = 1'b1; mRd = rd; mData = wb; mCount = mCount + 64'd1;
        end else begin
            mValid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (commit_valid !== mValid) begin
            failures++;
            $display("[TB] FAIL %s commit_valid got %b exp %b", tag, commit_valid, mValid);
        end
        checks++;
        if (commit_rd !== mRd) begin
            failures++;
            $display("[TB] FAIL %s commit_rd got %0d exp %0d", tag, commit_rd, mRd);
        end
        checks++;
        if (commit_data !== mData) begin
            failures++;
            $display("[TB] FAIL %s commit_data got %h exp %h", tag, commit_data, mData);
        end
        checks++;
        if (retired_count !== mCount) begin
            failures++;
            $display("[TB] FAIL %s retired_count got %h exp %h", tag, retired_count, mCount);
        end
    endtask

    task automatic idleRead(input string tag, input logic [4:0] rs1, input logic [4:0] rs2);
        cycle(tag, 1'b0, 64'hDEAD, 64'hBEEF, 5'd0, 1'b0, 1'b0, rs1, rs2);
    endtask

    task automatic test_reset();
        cycle("reset", 1'b1, '0, '0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            idleRead("reset_read", 5'(i), 5'(32 - i));
        end
    endtask

    task automatic test_write_read();
        cycle("write_x5", 1'b0, 64'h9999, 64'h1234, 5'd5, 1'b0, 1'b1, 5'd1, 5'd2);
        idleRead("read_x5", 5'd5, 5'd0);
        checks++;
        if (ID_rs1Data !== 64'h1234) begin
            failures++;
            $display("[TB] FAIL read_x5_const got %h exp %h", ID_rs1Data, 64'h1234);
        end
    endtask

    task automatic test_write_x0();
        cycle("write_x0", 1'b0, 64'hFFFF, 64'h1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
        idleRead("read_x0", 5'd0, 5'd0);
    endtask

    task automatic test_same_cycle();
        cycle("seed_x7", 1'b0, 64'h0, 64'h11, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0);
        cycle("bypass_x7", 1'b0, 64'hAA, 64'h0, 5'd7, 1'b1, 1'b1, 5'd7, 5'd7);
        idleRead("after_x7", 5'd7, 5'd7);
        cycle("bypass_split", 1'b0, 64'h0, 64'h77, 5'd9, 1'b0, 1'b1, 5'd9, 5'd7);
    endtask

    task automatic test_reset_priority();
        cycle("seed_x3", 1'b0, 64'h0, 64'h33, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0);
        cycle("rst_vs_write", 1'b1, 64'h0, 64'h55, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3);
        idleRead("read_x3", 5'd3, 5'd7);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [XLEN-1:0] mem, alu;
            mem = {$urandom, $urandom};
            alu = {$urandom, $urandom};
            cycle("random", ($urandom_range(0, 49) == 0), mem, alu,
                  5'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_wrap();
        force dut.retiredCount_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retiredCount_q;
        mCount = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle("wrap", 1'b0, 64'h0, 64'hC0DE, 5'd12, 1'b0, 1'b1, 5'd0, 5'd0);
        checks++;
        if (retired_count !== 64'd0) begin
            failures++;
            $display("[TB] FAIL wrap_zero got %h exp 0", retired_count);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mValid = 1'b0; mRd = '0; mData = '0; mCount = '0;
        rst = 1'b1; WB_MemData = '0; WB_ALUResult = '0; WB_rd = '0;
        WB_MemToReg = 1'b0; WB_RegWrite = 1'b0; ID_rs1 = '0; ID_rs2 = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_write_x0();
        test_same_cycle();
        test_reset_priority();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
